// File: rtl/instruction_decode.sv
// ID stage: IF/ID register, register file, branch resolve and hazard detection.
// Define ID_FWD_EN to forward aluOutM into the branch comparator.
module instruction_decode (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instrF,
  input  logic [31:0] pcPlus4F,
  output logic        PCSrcD,
  output logic [31:0] PCbranchD,
  output logic        write,
  input  logic        regWriteE,
  input  logic        memReadE,
  input  logic [4:0]  writeRegE,
  input  logic        regWriteM,
  input  logic        memReadM,
  input  logic [4:0]  writeRegM,
  input  logic [31:0] aluOutM,
  input  logic        regWriteW,
  input  logic [4:0]  writeRegW,
  input  logic [31:0] resultW,
  output logic [5:0]  opD,
  output logic [5:0]  functD,
  output logic [4:0]  rsD,
  output logic [4:0]  rtD,
  output logic [4:0]  rdD,
  output logic [31:0] rd1D,
  output logic [31:0] rd2D,
  output logic [31:0] signImmD,
  output logic        bubbleE
);

  logic [31:0] instrD_q, instrD_d;
  logic [31:0] pcPlus4D_q, pcPlus4D_d;
  logic        validD_q, validD_d;
  logic [31:0] rf_q [32];

  logic        branch, beq, bne;
  logic        eHit, mHit;
  logic        lwStall, brStall, stall;
  logic        fwdA, fwdB;
  logic [31:0] cmpA, cmpB;
  logic        taken;

  assign opD      = instrD_q[31:26];
  assign rsD      = instrD_q[25:21];
  assign rtD      = instrD_q[20:16];
  assign rdD      = instrD_q[15:11];
  assign functD   = instrD_q[5:0];
  assign signImmD = {{16{instrD_q[15]}}, instrD_q[15:0]};

  assign PCbranchD = pcPlus4D_q + {signImmD[29:0], 2'b00};

  // Write-back bypass so a same-cycle read sees the value being written.
  always_comb begin
    rd1D = rf_q[rsD];
    rd2D = rf_q[rtD];
    if (regWriteW && writeRegW != 5'd0 && writeRegW == rsD)
      rd1D = resultW;
    if (regWriteW && writeRegW != 5'd0 && writeRegW == rtD)
      rd2D = resultW;
    if (rsD == 5'd0)
      rd1D = '0;
    if (rtD == 5'd0)
      rd2D = '0;
  end

  assign beq    = (opD == 6'b000100);
  assign bne    = (opD == 6'b000101);
  assign branch = beq | bne;

  assign eHit = (writeRegE != 5'd0) &&
                (writeRegE == rsD || writeRegE == rtD);
  assign mHit = (writeRegM != 5'd0) &&
                (writeRegM == rsD || writeRegM == rtD);

  assign lwStall = memReadE && eHit;

`ifdef ID_FWD_EN
  assign brStall = branch &&
                   ((regWriteE && eHit) || (memReadM && mHit));
  assign fwdA = regWriteM && !memReadM &&
                writeRegM != 5'd0 && writeRegM == rsD;
  assign fwdB = regWriteM && !memReadM &&
                writeRegM != 5'd0 && writeRegM == rtD;
`else
  // No comparator bypass: any pending M-stage result blocks the branch.
  assign brStall = branch &&
                   ((regWriteE && eHit) ||
                    ((memReadM || regWriteM) && mHit));
  assign fwdA = 1'b0;
  assign fwdB = 1'b0;
`endif

  assign cmpA = fwdA ? aluOutM : rd1D;
  assign cmpB = fwdB ? aluOutM : rd2D;

  assign taken = beq ? (cmpA == cmpB) : (cmpA != cmpB);

  assign stall   = !reset && (lwStall || brStall);
  assign PCSrcD  = !reset && validD_q && branch &&
                   taken && !stall;
  assign write   = !stall;
  assign bubbleE = reset || stall || !validD_q;

  always_comb begin
    instrD_d   = instrD_q;
    pcPlus4D_d = pcPlus4D_q;
    validD_d   = validD_q;
    if (PCSrcD) begin
      instrD_d = '0;
      validD_d = 1'b0;
    end else if (write) begin
      instrD_d   = instrF;
      pcPlus4D_d = pcPlus4F;
      validD_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instrD_q   <= '0;
      pcPlus4D_q <= '0;
      validD_q   <= 1'b0;
      for (int i = 0; i < 32; i++)
        rf_q[i] <= '0;
    end else begin
      instrD_q   <= instrD_d;
      pcPlus4D_q <= pcPlus4D_d;
      validD_q   <= validD_d;
      if (regWriteW && writeRegW != 5'd0)
        rf_q[writeRegW] <= resultW;
    end
  end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL have ports: clk in 1 (rising edge); reset in 1 (synchronous, active-high).
REQ-002 SHALL have ports: instrF in 32 (fetched word); pcPlus4F in 32; PCSrcD out 1 (branch taken); PCbranchD out 32 (branch target); write out 1 (PC/IF enable, 0 = stall).
REQ-003 SHALL have ports: regWriteE in 1; memReadE in 1; writeRegE in 5; regWriteM in 1; memReadM in 1; writeRegM in 5; aluOutM in 32.
REQ-004 SHALL have ports: regWriteW in 1; writeRegW in 5; resultW in 32 (write-back port).
REQ-005 SHALL have ports: opD out 6; functD out 6; rsD, rtD, rdD out 5 each; rd1D, rd2D out 32; signImmD out 32; bubbleE out 1 (insert nop into ID/EX).

Function
REQ-006 SHALL hold an IF/ID register (instrD, pcPlus4D, validD), loaded from instrF/pcPlus4F on each edge when write=1 and no flush.
REQ-007 SHALL hold IF/ID unchanged when write=0 (stall).
REQ-008 SHALL flush IF/ID (instrD=0, validD=0) on the edge where PCSrcD=1; flush wins over load.
REQ-009 SHALL contain a 32x32 register file; $0 reads 0 and ignores writes.
REQ-010 SHALL write resultW to writeRegW on the rising edge when regWriteW=1.
REQ-011 SHALL bypass write-back: a same-cycle read of writeRegW (non-zero, regWriteW=1) returns resultW.
REQ-012 SHALL decode fields combinationally from instrD; signImmD = sign-extend instrD[15:0].
REQ-013 SHALL compute PCbranchD = pcPlus4D + (signImmD << 2), modulo 2^32.
REQ-014 SHALL treat opD 000100 as beq and 000101 as bne; taken when operands equal / not equal.
REQ-015 SHALL assert PCSrcD = validD AND branch AND taken AND NOT stall.
REQ-016 SHALL assert load-use stall when memReadE=1, writeRegE!=0 and writeRegE equals rsD or rtD.
REQ-017 SHALL assert branch stall when branch in D and regWriteE=1, writeRegE!=0, matching rsD/rtD.
REQ-018 SHALL assert branch stall when branch in D and memReadM=1, writeRegM!=0, matching rsD/rtD.
REQ-019 SHALL drive write = NOT stall and bubbleE = stall OR NOT validD.
REQ-020 SHALL treat rs/rt matches against register 0 as never hazardous.

Reset
REQ-021 SHALL, on the edge with reset=1: instrD=0, pcPlus4D=0, validD=0, all 32 registers = 0.
REQ-022 SHALL, while reset=1, output PCSrcD=0, write=1, bubbleE=1; reset overrides stall and flush.
REQ-023 SHALL give reset mid-stall the same result as reset from idle; the first instruction after reset loads on the next edge.

Configuration
REQ-024 SHALL use macro ID_FWD_EN to select ID-stage branch forwarding.
REQ-025 With ID_FWD_EN defined, SHALL forward aluOutM to the branch comparator when regWriteM=1, memReadM=0 and writeRegM matches (non-zero).
REQ-026 Without ID_FWD_EN, SHALL instead stall the branch for any regWriteM=1 with a matching non-zero writeRegM.
REQ-027 rd1D/rd2D outputs SHALL be the unforwarded register-file values in both builds.

Verification
REQ-028 Setup: write $8=5 and $9=5 via WB; feed beq $8,$9,+2 at pcPlus4F=0x10. Response: next cycle PCSrcD=1, PCbranchD=0x18; the following edge gives validD=0, instrD=0.
REQ-029 Setup: $8=5, $9=6, same beq. Response: PCSrcD=0; bne with the same operands gives PCSrcD=1.
REQ-030 Setup: memReadE=1, writeRegE=8, add $10,$8,$9 in D. Response: write=0 and bubbleE=1 for one cycle; instrD held; write=1 when memReadE drops.
REQ-031 Setup: regWriteM=1, writeRegM=8, aluOutM=7, $9=7, beq $8,$9 in D. Response: with ID_FWD_EN, PCSrcD=1 with no stall; without it, one stall cycle.
REQ-032 Setup: regWriteW=1, writeRegW=8, resultW=0xDEADBEEF, read of $8 in the same cycle. Response: rd1D=0xDEADBEEF; a write to $0 still reads 0.
REQ-033 Setup: assert reset during a load-use stall. Response: after the edge, validD=0, write=1, all registers read 0.
